// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters,
// with a one-entry owner-tagged response register and an illegal-opcode screen.
module alu_share_arbiter #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [XLEN-1:0]   req0_a,
  input  logic [XLEN-1:0]   req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [XLEN-1:0]   req1_a,
  input  logic [XLEN-1:0]   req1_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]   alu_op_a,
  output logic [XLEN-1:0]   alu_op_b,
  input  logic [XLEN-1:0]   alu_result,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic [1:0]        dbg_state
);

  // Handshakes: a request is accepted on a rising edge where reqN_valid && reqN_ready;
  // a response is consumed on a rising edge where rspN_valid && rspN_ready.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } rsp_state_e;

  rsp_state_e state, state_next;
  logic       rr_ptr;
  logic       free, grant0, grant1, any_grant, sel_legal;

  function automatic logic is_legal(input logic [CTRL_W-1:0] c);
    logic ok;
    ok = 1'b0;
    if (c == CTRL_W'(6'b000000) || c == CTRL_W'(6'b001000) || c == CTRL_W'(6'b000010) ||
        c == CTRL_W'(6'b000100) || c == CTRL_W'(6'b000111))
      ok = 1'b1;
    return ok;
  endfunction

  always_comb begin
    free       = (state == EMPTY) || (state == HOLD0 && rsp0_ready) ||
                 (state == HOLD1 && rsp1_ready);
    grant0     = free && req0_valid && (!req1_valid || !rr_ptr);
    grant1     = free && req1_valid && (!req0_valid ||  rr_ptr);
    any_grant  = grant0 || grant1;
    alu_ctrl   = '0;
    alu_op_a   = '0;
    alu_op_b   = '0;
    state_next = state;
    if (grant0) begin
      alu_ctrl = req0_ctrl;
      alu_op_a = req0_a;
      alu_op_b = req0_b;
    end else if (grant1) begin
      alu_ctrl = req1_ctrl;
      alu_op_a = req1_a;
      alu_op_b = req1_b;
    end
    sel_legal = is_legal(alu_ctrl);
    if (grant0)      state_next = HOLD0;
    else if (grant1) state_next = HOLD1;
    else if (free)   state_next = EMPTY;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_next;
  end

  // Data and error only move on a grant; after a drain they keep the last value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      rr_ptr     <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (any_grant) begin
        rsp_data <= sel_legal ? alu_result : '0;
        rsp_err  <= !sel_legal;
        rr_ptr   <= grant0;
      end
      if (grant0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (grant1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state == HOLD0);
  assign rsp1_valid = (state == HOLD1);
  assign dbg_state  = state;

endmodule
